// File: rtl/stack_seq_if.sv
// Bundle of the stack sequencer's request, stack-pointer, memory and result signals.
// slave is the sequencer side; master is the requester/memory/S-register side.
interface stack_seq_if;
   logic        req_valid;
   logic [1:0]  req_op;
   logic [15:0] req_data;
   logic        req_ready;

   logic [7:0]  s_in;
   logic        s_load;
   logic [7:0]  s_next;

   logic [15:0] mem_addr;
   logic        mem_we;
   logic [7:0]  mem_wdata;
   logic        mem_re;
   logic [7:0]  mem_rdata;

   logic        done;
   logic [15:0] rdata;
   logic        wrap;

   modport slave (
      input  req_valid, req_op, req_data, s_in, mem_rdata,
      output req_ready, s_load, s_next, mem_addr, mem_we, mem_wdata, mem_re,
             done, rdata, wrap
   );

   modport master (
      output req_valid, req_op, req_data, s_in, mem_rdata,
      input  req_ready, s_load, s_next, mem_addr, mem_we, mem_wdata, mem_re,
             done, rdata, wrap
   );
endinterface

// File: rtl/stack_seq.sv
// Page-1 stack push/pull sequencer: byte/word pushes (post-decrement) and pulls
// (pre-increment) against a byte memory, handing the updated S back on completion.
module stack_seq (
   input  logic              clk,
   input  logic              rst_n,
   stack_seq_if.slave        bus
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      WR1  = 3'd1,
      WR2  = 3'd2,
      RD1  = 3'd3,
      CAP1 = 3'd4,
      CAP2 = 3'd5,
      FIN  = 3'd6
   } state_t;

   state_t      state_q, state_d;
   logic [7:0]  ptr_q, ptr_d;
   logic [1:0]  op_q, op_d;
   logic [15:0] data_q, data_d;
   logic [15:0] rdata_q, rdata_d;
   logic        wrap_q, wrap_d;

   logic        is_word;
   logic [7:0]  ptr_inc, ptr_dec;

   assign is_word = op_q[1];
   assign ptr_inc = ptr_q + 8'd1;
   assign ptr_dec = ptr_q - 8'd1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ptr_q   <= 8'h00;
         op_q    <= 2'b00;
         data_q  <= 16'h0000;
         rdata_q <= 16'h0000;
         wrap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         op_q    <= op_d;
         data_q  <= data_d;
         rdata_q <= rdata_d;
         wrap_q  <= wrap_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      ptr_d         = ptr_q;
      op_d          = op_q;
      data_d        = data_q;
      rdata_d       = rdata_q;
      wrap_d        = wrap_q;

      bus.req_ready = 1'b0;
      bus.s_load    = 1'b0;
      bus.s_next    = ptr_q;
      bus.mem_addr  = {8'h01, ptr_q};
      bus.mem_we    = 1'b0;
      bus.mem_wdata = data_q[7:0];
      bus.mem_re    = 1'b0;
      bus.done      = 1'b0;
      bus.wrap      = 1'b0;

      case (state_q)
         IDLE: begin
            bus.req_ready = 1'b1;
            if (bus.req_valid) begin
               op_d    = bus.req_op;
               data_d  = bus.req_data;
               ptr_d   = bus.s_in;
               wrap_d  = 1'b0;
               state_d = bus.req_op[0] ? RD1 : WR1;
            end
         end

         // A word push stores the high byte first so a pull returns it last.
         WR1: begin
            bus.mem_we    = 1'b1;
            bus.mem_wdata = is_word ? data_q[15:8] : data_q[7:0];
            ptr_d         = ptr_dec;
            if (ptr_q == 8'h00) wrap_d = 1'b1;
            state_d       = is_word ? WR2 : FIN;
         end

         WR2: begin
            bus.mem_we    = 1'b1;
            bus.mem_wdata = data_q[7:0];
            ptr_d         = ptr_dec;
            if (ptr_q == 8'h00) wrap_d = 1'b1;
            state_d       = FIN;
         end

         RD1: begin
            bus.mem_re   = 1'b1;
            bus.mem_addr = {8'h01, ptr_inc};
            ptr_d        = ptr_inc;
            if (ptr_q == 8'hFF) wrap_d = 1'b1;
            state_d      = CAP1;
         end

         // Capture of the first byte overlaps the second read of a word pull.
         CAP1: begin
            if (is_word) begin
               rdata_d[7:0] = bus.mem_rdata;
               bus.mem_re   = 1'b1;
               bus.mem_addr = {8'h01, ptr_inc};
               ptr_d        = ptr_inc;
               if (ptr_q == 8'hFF) wrap_d = 1'b1;
               state_d      = CAP2;
            end else begin
               rdata_d = {8'h00, bus.mem_rdata};
               state_d = FIN;
            end
         end

         CAP2: begin
            rdata_d[15:8] = bus.mem_rdata;
            state_d       = FIN;
         end

         FIN: begin
            bus.done   = 1'b1;
            bus.s_load = 1'b1;
            bus.s_next = ptr_q;
            bus.wrap   = wrap_q;
            state_d    = IDLE;
         end

         default: state_d = IDLE;
      endcase
   end

   assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_stack_seq.sv
// Directed bench for stack_seq: byte/word push/pull, pointer wrap, back-to-back
// handoff through an S register model, and reset in the middle of a push.
module tb_stack_seq;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   stack_seq_if bus();

   stack_seq dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // S register and page-1 memory surrounding the sequencer
   logic [7:0] s_reg;
   logic [7:0] s_drv;
   logic       s_sel;
   logic [7:0] mem [256];

   assign bus.s_in = s_sel ? s_reg : s_drv;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)          s_reg <= 8'h00;
      else if (bus.s_load) s_reg <= bus.s_next;
   end

   always_ff @(posedge clk) begin
      if (bus.mem_we) mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
      if (bus.mem_re) bus.mem_rdata <= mem[bus.mem_addr[7:0]];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Mid-operation cycle: expected strobes, no completion
   task automatic chk_bus(input string tag, input logic we, input logic re,
                          input logic [15:0] addr, input logic [7:0] wd);
      chk({tag, ".we"}, 32'(bus.mem_we), 32'(we));
      chk({tag, ".re"}, 32'(bus.mem_re), 32'(re));
      chk({tag, ".done"}, 32'(bus.done), 32'd0);
      chk({tag, ".sload"}, 32'(bus.s_load), 32'd0);
      chk({tag, ".ready"}, 32'(bus.req_ready), 32'd0);
      if (we || re) chk({tag, ".addr"}, 32'(bus.mem_addr), 32'(addr));
      if (we) chk({tag, ".wdata"}, 32'(bus.mem_wdata), 32'(wd));
   endtask

   task automatic chk_fin(input string tag, input logic [7:0] snext, input logic wr);
      chk({tag, ".done"}, 32'(bus.done), 32'd1);
      chk({tag, ".sload"}, 32'(bus.s_load), 32'd1);
      chk({tag, ".snext"}, 32'(bus.s_next), 32'(snext));
      chk({tag, ".wrap"}, 32'(bus.wrap), 32'(wr));
      chk({tag, ".we"}, 32'(bus.mem_we), 32'd0);
      chk({tag, ".re"}, 32'(bus.mem_re), 32'd0);
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, ".ready"}, 32'(bus.req_ready), 32'd1);
      chk({tag, ".done"}, 32'(bus.done), 32'd0);
      chk({tag, ".wrap"}, 32'(bus.wrap), 32'd0);
   endtask

   task automatic req(input logic [1:0] op, input logic [15:0] data, input logic [7:0] s);
      bus.req_valid = 1'b1;
      bus.req_op    = op;
      bus.req_data  = data;
      s_drv         = s;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      checks        = 0;
      errors        = 0;
      s_sel         = 1'b0;
      s_drv         = 8'h00;
      bus.req_valid = 1'b0;
      bus.req_op    = 2'b00;
      bus.req_data  = 16'h0000;
      rst_n         = 1'b0;

      // Reset state
      #2;
      chk("rst.ready", 32'(bus.req_ready), 32'd1);
      chk("rst.done", 32'(bus.done), 32'd0);
      chk("rst.we", 32'(bus.mem_we), 32'd0);
      chk("rst.re", 32'(bus.mem_re), 32'd0);
      chk("rst.sload", 32'(bus.s_load), 32'd0);
      chk("rst.wrap", 32'(bus.wrap), 32'd0);
      chk("rst.rdata", 32'(bus.rdata), 32'd0);
      #10;
      rst_n = 1'b1;

      // Push byte from S=FF
      req(2'b00, 16'h00AB, 8'hFF);
      step();
      bus.req_valid = 1'b0;
      s_drv = 8'h5A;
      chk_bus("pb1.wr1", 1'b1, 1'b0, 16'h01FF, 8'hAB);
      step();
      chk_fin("pb1.fin", 8'hFE, 1'b0);
      chk("pb1.mem", 32'(mem[8'hFF]), 32'hAB);
      step();
      chk_idle("pb1.idle");

      // Push word from S=FD, requester then holds a pull word through it
      req(2'b10, 16'h1234, 8'hFD);
      step();
      bus.req_op   = 2'b11;
      bus.req_data = 16'hFFFF;
      s_sel        = 1'b1;
      chk_bus("pw.wr1", 1'b1, 1'b0, 16'h01FD, 8'h12);
      step();
      chk_bus("pw.wr2", 1'b1, 1'b0, 16'h01FC, 8'h34);
      step();
      chk_fin("pw.fin", 8'hFB, 1'b0);
      step();
      chk_idle("pw.idle");
      step();
      bus.req_valid = 1'b0;
      chk_bus("pl.rd1", 1'b0, 1'b1, 16'h01FC, 8'h00);
      step();
      chk_bus("pl.cap1", 1'b0, 1'b1, 16'h01FD, 8'h00);
      step();
      chk_bus("pl.cap2", 1'b0, 1'b0, 16'h0000, 8'h00);
      step();
      chk_fin("pl.fin", 8'hFD, 1'b0);
      chk("pl.rdata", 32'(bus.rdata), 32'h1234);
      step();
      s_sel = 1'b0;

      // Push byte from S=00 wraps to FF; rdata holds
      req(2'b00, 16'h0055, 8'h00);
      step();
      bus.req_valid = 1'b0;
      chk_bus("pbw.wr1", 1'b1, 1'b0, 16'h0100, 8'h55);
      chk("pbw.rdhold", 32'(bus.rdata), 32'h1234);
      step();
      chk_fin("pbw.fin", 8'hFF, 1'b1);
      chk("pbw.rdhold2", 32'(bus.rdata), 32'h1234);
      step();
      chk_idle("pbw.idle");

      // Pull byte from S=FF wraps to 00; high byte cleared
      req(2'b01, 16'h0000, 8'hFF);
      step();
      bus.req_valid = 1'b0;
      chk_bus("plb.rd1", 1'b0, 1'b1, 16'h0100, 8'h00);
      step();
      chk_bus("plb.cap1", 1'b0, 1'b0, 16'h0000, 8'h00);
      step();
      chk_fin("plb.fin", 8'h00, 1'b1);
      chk("plb.rdata", 32'(bus.rdata), 32'h0055);
      step();
      chk_idle("plb.idle");

      // Reset during WR2 of a push word
      req(2'b10, 16'hABCD, 8'h10);
      step();
      bus.req_valid = 1'b0;
      step();
      chk_bus("rsw.wr2", 1'b1, 1'b0, 16'h010F, 8'hCD);
      #1;
      rst_n = 1'b0;
      #1;
      chk("rsw.we", 32'(bus.mem_we), 32'd0);
      chk("rsw.ready", 32'(bus.req_ready), 32'd1);
      chk("rsw.sload", 32'(bus.s_load), 32'd0);
      chk("rsw.rdata", 32'(bus.rdata), 32'd0);
      step();
      chk("rsw.sload2", 32'(bus.s_load), 32'd0);
      chk("rsw.done2", 32'(bus.done), 32'd0);
      rst_n = 1'b1;
      req(2'b00, 16'h00C3, 8'hFF);
      step();
      bus.req_valid = 1'b0;
      chk_bus("rsp.wr1", 1'b1, 1'b0, 16'h01FF, 8'hC3);
      step();
      chk_fin("rsp.fin", 8'hFE, 1'b0);
      step();
      chk_idle("rsp.idle");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/stack_seq.md
STACK_SEQ -- requirements
Module: stack_seq

Interface
REQ-001 SHALL have port clk  in  1  rising-edge clock.
REQ-002 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have port req_valid  in  1  stack operation request.
REQ-004 SHALL have port req_op  in  2  operation: 00 push byte, 01 pull byte, 10 push word, 11 pull word.
REQ-005 SHALL have port req_data  in  16  push data; byte push uses [7:0]; word push sends [15:8] first, then [7:0].
REQ-006 SHALL have port req_ready  out  1  high only in IDLE.
REQ-007 SHALL have port s_in  in  8  current stack pointer S, from the S register output.
REQ-008 SHALL have port s_load  out  1  load strobe to the S register.
REQ-009 SHALL have port s_next  out  8  new S value; meaningful only while s_load=1.
REQ-010 SHALL have port mem_addr  out  16  stack address {8'h01, ptr}.
REQ-011 SHALL have port mem_we  out  1  write strobe.
REQ-012 SHALL have port mem_wdata  out  8  write data.
REQ-013 SHALL have port mem_re  out  1  read strobe.
REQ-014 SHALL have port mem_rdata  in  8  read data, valid in the cycle after mem_re.
REQ-015 SHALL have port done  out  1  one-cycle completion pulse.
REQ-016 SHALL have port rdata  out  16  pulled data; byte pull writes [7:0] and clears [15:8].
REQ-017 SHALL have port wrap  out  1  one-cycle flag, coincident with done, set if the pointer wrapped during the operation.

Function
REQ-018 SHALL accept a request on a rising edge where req_valid=1 and req_ready=1, latching req_op, req_data and ptr<=s_in.
REQ-019 SHALL implement states IDLE, WR1, WR2, RD1, CAP1, CAP2 and FIN.
REQ-020 SHALL take these transitions: push byte IDLE->WR1->FIN; push word IDLE->WR1->WR2->FIN; pull byte IDLE->RD1->CAP1->FIN; pull word IDLE->RD1->CAP1->CAP2->FIN; FIN->IDLE always.
REQ-021 SHALL in each WRn cycle drive mem_we=1, mem_addr={01,ptr} and mem_wdata=the current byte, then set ptr<=ptr-1 (mod 256); the push is post-decrement.
REQ-022 SHALL in RD1 drive mem_re=1 with mem_addr={01,ptr+1} and set ptr<=ptr+1; the pull is pre-increment.
REQ-023 SHALL for a byte pull, in CAP1, load rdata<={8'h00,mem_rdata}.
REQ-024 SHALL for a word pull, in CAP1, capture rdata[7:0]<=mem_rdata, drive mem_re=1 with mem_addr={01,ptr+1}, and set ptr<=ptr+1.
REQ-025 SHALL for a word pull, in CAP2, load rdata[15:8]<=mem_rdata.
REQ-026 SHALL in FIN drive done=1, s_load=1 and s_next=ptr; it SHALL assert s_load in no other state.
REQ-027 SHALL never assert mem_we and mem_re in the same cycle, and SHALL assert neither in IDLE or FIN.
REQ-028 SHALL set latencies from accept edge to the done cycle as: push byte 2, push word 3, pull byte 3, pull word 4 cycles.
REQ-029 SHALL hold rdata stable from FIN until the next pull's capture cycle.
REQ-030 SHALL set wrap in FIN if any decrement from 8'h00 or increment from 8'hFF occurred during the operation; the wrap itself is silent, with no stall or abort.
REQ-031 SHALL ignore req_valid outside IDLE; a request then is neither lost nor queued, and the requester holds it until req_ready.
REQ-032 SHALL support back-to-back operation: the next accept is possible in the IDLE cycle after FIN, where s_in already reflects the s_next just loaded.
REQ-033 SHALL ignore s_in except at the accept edge.

Reset
REQ-034 SHALL on rst_n=0 force immediately, asynchronously: state=IDLE, ptr=0, rdata=0, and req_ready=1 once state is IDLE.
REQ-035 SHALL hold done, wrap, s_load, mem_we and mem_re at 0 while rst_n=0.
REQ-036 SHALL on reset mid-operation abandon the operation with no further strobes and no s_load; it SHALL resume accepting on the first edge after rst_n rises.

Verification
REQ-037 SHALL pass: push byte, s_in=FF, req_data=00AB -> WR1 write 01FF<=AB; FIN s_load, s_next=FE, done=1, wrap=0.
REQ-038 SHALL pass: push word, s_in=FD, req_data=1234 -> writes 01FD<=12 then 01FC<=34; s_next=FB; done 3 cycles after accept.
REQ-039 SHALL pass: pull word, s_in=FB, memory 01FC=34 and 01FD=12 -> reads 01FC then 01FD; rdata=1234, s_next=FD, done 4 cycles after accept.
REQ-040 SHALL pass: push byte, s_in=00 -> write 0100; s_next=FF, wrap=1.
REQ-041 SHALL pass: pull byte, s_in=FF -> read 0100; s_next=00, wrap=1, rdata[15:8]=00.
REQ-042 SHALL pass: rst_n low in WR2 of a push word -> mem_we drops immediately, no s_load, req_ready=1; a following push byte with s_in=FF completes normally.
